// File: rtl/interrupt_responder.sv
// rtl/interrupt_responder.sv - kernel interrupt capture, round-robin forwarding to host with retry/backoff
module interrupt_responder #(
    parameter int NUM_KERNELS = 4,
    parameter int CTXW        = 9,
    parameter int KIDW        = 2,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_DELAY = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KERNELS-1:0]        k_intr_req,
    input  logic [64*NUM_KERNELS-1:0]     k_intr_src,
    input  logic [CTXW*NUM_KERNELS-1:0]   k_intr_ctx,
    output logic [NUM_KERNELS-1:0]        k_intr_ack,
    output logic                          host_intr_valid,
    input  logic                          host_intr_ready,
    output logic [63:0]                   host_intr_src,
    output logic [CTXW-1:0]               host_intr_ctx,
    output logic [KIDW-1:0]               host_intr_kid,
    input  logic                          host_rsp_valid,
    input  logic                          host_rsp_ok,
    output logic                          busy,
    output logic [NUM_KERNELS-1:0]        err_overrun,
    output logic [NUM_KERNELS-1:0]        err_drop,
    output logic                          err_spurious
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_BACKOFF, S_ACK} state_t;

    state_t                  state_q, state_d;
    logic [NUM_KERNELS-1:0]  pending_q, pending_d;
    logic [63:0]             src_q [NUM_KERNELS];
    logic [63:0]             src_d [NUM_KERNELS];
    logic [CTXW-1:0]         ctx_q [NUM_KERNELS];
    logic [CTXW-1:0]         ctx_d [NUM_KERNELS];
    logic [KIDW-1:0]         last_q, last_d;
    logic [KIDW-1:0]         grant_q, grant_d;
    logic [3:0]              retry_q, retry_d;
    logic [15:0]             delay_q, delay_d;
    logic                    valid_q, valid_d;
    logic [63:0]             hsrc_q, hsrc_d;
    logic [CTXW-1:0]         hctx_q, hctx_d;
    logic [KIDW-1:0]         hkid_q, hkid_d;
    logic [NUM_KERNELS-1:0]  ack_q, ack_d;
    logic [NUM_KERNELS-1:0]  overrun_q, overrun_d;
    logic [NUM_KERNELS-1:0]  drop_q, drop_d;
    logic                    spur_q, spur_d;
    logic [NUM_KERNELS-1:0]  clear;
    logic                    pick_found;
    logic [KIDW-1:0]         pick_idx;

    // Round-robin: scan indices above last first, then wrap to 0..last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (!pick_found && pending_q[i] && (i > int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = KIDW'(i);
            end
        end
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (!pick_found && pending_q[i] && (i <= int'(last_q))) begin
                pick_found = 1'b1;
                pick_idx   = KIDW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        retry_d = retry_q;
        delay_d = delay_q;
        valid_d = valid_q;
        hsrc_d  = hsrc_q;
        hctx_d  = hctx_q;
        hkid_d  = hkid_q;
        ack_d   = '0;
        clear   = '0;
        drop_d  = drop_q;
        spur_d  = spur_q;
        if (host_rsp_valid && (state_q != S_WAIT_RSP)) begin
            spur_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    hsrc_d  = src_q[grant_q];
                    hctx_d  = ctx_q[grant_q];
                    hkid_d  = grant_q;
                end else if (host_intr_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (host_rsp_valid) begin
                    if (host_rsp_ok) begin
                        state_d = S_ACK;
                    end else if (int'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 4'd1;
                        delay_d = '0;
                        state_d = S_BACKOFF;
                    end else begin
                        drop_d[grant_q] = 1'b1;
                        state_d         = S_ACK;
                    end
                end
            end
            S_BACKOFF: begin
                if (int'(delay_q) >= RETRY_DELAY - 1) begin
                    state_d = S_ISSUE;
                end else begin
                    delay_d = delay_q + 16'd1;
                end
            end
            S_ACK: begin
                ack_d[grant_q] = 1'b1;
                clear[grant_q] = 1'b1;
                retry_d        = '0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request landing on the slot's clearing edge is a fresh capture, not an overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            src_d[i] = src_q[i];
            ctx_d[i] = ctx_q[i];
            if (k_intr_req[i]) begin
                if (pending_q[i] && !clear[i]) begin
                    overrun_d[i] = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    src_d[i]     = k_intr_src[64*i +: 64];
                    ctx_d[i]     = k_intr_ctx[CTXW*i +: CTXW];
                end
            end else if (clear[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            for (int i = 0; i < NUM_KERNELS; i++) begin
                src_q[i] <= '0;
                ctx_q[i] <= '0;
            end
            last_q    <= KIDW'(NUM_KERNELS - 1);
            grant_q   <= '0;
            retry_q   <= '0;
            delay_q   <= '0;
            valid_q   <= 1'b0;
            hsrc_q    <= '0;
            hctx_q    <= '0;
            hkid_q    <= '0;
            ack_q     <= '0;
            overrun_q <= '0;
            drop_q    <= '0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_KERNELS; i++) begin
                src_q[i] <= src_d[i];
                ctx_q[i] <= ctx_d[i];
            end
            last_q    <= last_d;
            grant_q   <= grant_d;
            retry_q   <= retry_d;
            delay_q   <= delay_d;
            valid_q   <= valid_d;
            hsrc_q    <= hsrc_d;
            hctx_q    <= hctx_d;
            hkid_q    <= hkid_d;
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            spur_q    <= spur_d;
        end
    end

    assign k_intr_ack      = ack_q;
    assign host_intr_valid = valid_q;
    assign host_intr_src   = hsrc_q;
    assign host_intr_ctx   = hctx_q;
    assign host_intr_kid   = hkid_q;
    assign busy            = (state_q != S_IDLE) || (|pending_q);
    assign err_overrun     = overrun_q;
    assign err_drop        = drop_q;
    assign err_spurious    = spur_q;

endmodule

// File: tb/tb_interrupt_responder.sv
// tb/tb_interrupt_responder.sv - randomized bench with timestamp-based reference model for interrupt_responder
module tb_interrupt_responder;
    localparam int NK   = 4;
    localparam int CTXW = 9;
    localparam int KIDW = 2;
    localparam int MAXR = 3;
    localparam int RD   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NK-1:0]        k_intr_req;
    logic [64*NK-1:0]     k_intr_src;
    logic [CTXW*NK-1:0]   k_intr_ctx;
    logic [NK-1:0]        k_intr_ack;
    logic                 host_intr_valid, host_intr_ready;
    logic [63:0]          host_intr_src;
    logic [CTXW-1:0]      host_intr_ctx;
    logic [KIDW-1:0]      host_intr_kid;
    logic                 host_rsp_valid, host_rsp_ok, busy;
    logic [NK-1:0]        err_overrun, err_drop;
    logic                 err_spurious;

    interrupt_responder #(.NUM_KERNELS(NK), .CTXW(CTXW), .KIDW(KIDW),
                          .MAX_RETRY(MAXR), .RETRY_DELAY(RD)) dut (
        .clk(clk), .rst(rst), .k_intr_req(k_intr_req), .k_intr_src(k_intr_src),
        .k_intr_ctx(k_intr_ctx), .k_intr_ack(k_intr_ack), .host_intr_valid(host_intr_valid),
        .host_intr_ready(host_intr_ready), .host_intr_src(host_intr_src),
        .host_intr_ctx(host_intr_ctx), .host_intr_kid(host_intr_kid),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ok(host_rsp_ok), .busy(busy),
        .err_overrun(err_overrun), .err_drop(err_drop), .err_spurious(err_spurious));

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    // Reference model: per-kernel capture timestamps and scheduled ack ticks
    bit              m_pend [NK];
    logic [63:0]     m_src [NK];
    logic [CTXW-1:0] m_ctx [NK];
    int              m_cap [NK];
    int              m_ack_tick [NK];
    int              m_last;
    logic [NK-1:0]   exp_overrun, exp_drop;
    logic            exp_spur;
    bit              txn_active, outstanding, force_spur, ready_always, prev_valid;
    int              txn_kid, txn_fails, fail_edge, rsp_timer, rsp_delay_fixed, ok_pct;
    bit              rsp_plan [$];
    int              dut_kids [$];
    logic [NK-1:0]   req_v;
    logic [63:0]     req_src [NK];
    logic [CTXW-1:0] req_ctx [NK];
    logic [63:0]     prev_src, last_issue_src;
    logic [CTXW-1:0] prev_ctx;
    logic [KIDW-1:0] prev_kid;
    int              issues_total, first_valid_tick;
    int              ack_cnt [NK];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_grant(input int c);
        for (int off = 1; off <= NK; off++) begin
            int j;
            j = (m_last + off) % NK;
            if (m_pend[j] && m_cap[j] <= c - 2) return j;
        end
        return -1;
    endfunction

    function automatic bit model_idle();
        bit r;
        r = !txn_active && !outstanding;
        for (int i = 0; i < NK; i++) if (m_pend[i] || m_ack_tick[i] != -1) r = 1'b0;
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NK; i++) begin
            m_pend[i] = 1'b0; m_cap[i] = 0; m_ack_tick[i] = -1;
        end
        m_last = NK - 1;
        exp_overrun = '0; exp_drop = '0; exp_spur = 1'b0;
        txn_active = 1'b0; outstanding = 1'b0; force_spur = 1'b0; prev_valid = 1'b0;
        rsp_timer = -1; rsp_plan.delete();
    endtask

    task automatic post_check();
        logic [NK-1:0] expv;
        int g;
        for (int i = 0; i < NK; i++) expv[i] = (m_ack_tick[i] == cyc);
        check_eq("ack", k_intr_ack, expv);
        for (int i = 0; i < NK; i++) begin
            if (k_intr_ack[i]) ack_cnt[i]++;
            if (m_ack_tick[i] == cyc) m_ack_tick[i] = -1;
        end
        if (prev_valid && host_intr_ready) begin
            check_eq("valid_drop", host_intr_valid, 0);
            outstanding  = 1'b1;
            rsp_timer    = (rsp_delay_fixed >= 0) ? rsp_delay_fixed : $urandom_range(0, 3);
            issues_total++;
        end else if (prev_valid) begin
            check_eq("valid_hold", host_intr_valid, 1);
            check_eq("src_hold", host_intr_src, prev_src);
            check_eq("ctx_hold", host_intr_ctx, prev_ctx);
            check_eq("kid_hold", host_intr_kid, prev_kid);
        end
        check_eq("one_outstanding", host_intr_valid && outstanding, 0);
        if (host_intr_valid && !prev_valid) begin
            if (txn_active) begin
                check_eq("retry_kid", host_intr_kid, txn_kid);
                check_eq("backoff_gap", (cyc - fail_edge) >= RD, 1);
            end else begin
                g = exp_grant(cyc);
                check_eq("grant", 64'(host_intr_kid), 64'(g));
                txn_active = 1'b1;
                txn_kid    = (g < 0) ? 0 : g;
                txn_fails  = 0;
                m_last     = txn_kid;
                dut_kids.push_back(int'(host_intr_kid));
                first_valid_tick = cyc;
            end
            last_issue_src = host_intr_src;
            check_eq("issue_src", host_intr_src, m_src[txn_kid]);
            check_eq("issue_ctx", host_intr_ctx, m_ctx[txn_kid]);
        end
        prev_valid = host_intr_valid;
        prev_src   = host_intr_src;
        prev_ctx   = host_intr_ctx;
        prev_kid   = host_intr_kid;
    endtask

    task automatic step();
        int e;
        bit clr, ok;
        e = cyc + 1;
        for (int i = 0; i < NK; i++) begin
            clr = (m_ack_tick[i] == e);
            if (req_v[i]) begin
                if (m_pend[i] && !clr) exp_overrun[i] = 1'b1;
                else begin
                    m_pend[i] = 1'b1; m_src[i] = req_src[i]; m_ctx[i] = req_ctx[i]; m_cap[i] = e;
                end
            end else if (clr) begin
                m_pend[i] = 1'b0;
            end
            k_intr_src[64*i +: 64]     = req_v[i] ? req_src[i] : {$urandom, $urandom};
            k_intr_ctx[CTXW*i +: CTXW] = req_v[i] ? req_ctx[i] : CTXW'($urandom);
        end
        k_intr_req      = req_v;
        host_intr_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        host_rsp_valid  = 1'b0;
        host_rsp_ok     = 1'($urandom_range(0, 1));
        if (force_spur) begin
            host_rsp_valid = 1'b1; exp_spur = 1'b1; force_spur = 1'b0;
        end else if (outstanding) begin
            if (rsp_timer == 0) begin
                if (rsp_plan.size() > 0) ok = rsp_plan.pop_front();
                else ok = ($urandom_range(0, 99) < ok_pct);
                host_rsp_valid = 1'b1; host_rsp_ok = ok; outstanding = 1'b0;
                if (ok) begin
                    m_ack_tick[txn_kid] = e + 1; txn_active = 1'b0;
                end else if (txn_fails < MAXR) begin
                    txn_fails++; fail_edge = e;
                end else begin
                    exp_drop[txn_kid] = 1'b1; m_ack_tick[txn_kid] = e + 1; txn_active = 1'b0;
                end
            end else begin
                rsp_timer--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        post_check();
        req_v = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_v = '0; k_intr_req = '0; host_rsp_valid = 1'b0; host_intr_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        reset_model();
        check_eq("rst_ack", k_intr_ack, 0);
        check_eq("rst_valid", host_intr_valid, 0);
        check_eq("rst_src", host_intr_src, 0);
        check_eq("rst_ctx", host_intr_ctx, 0);
        check_eq("rst_kid", host_intr_kid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", err_overrun, 0);
        check_eq("rst_drop", err_drop, 0);
        check_eq("rst_spurious", err_spurious, 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !model_idle()) begin
            step();
            n++;
        end
        check_eq("drain_bound", n < budget, 1);
        step();
        step();
        check_eq("busy_idle", busy, 0);
    endtask

    task automatic set_req(input int k, input logic [63:0] s, input logic [CTXW-1:0] x);
        req_v[k] = 1'b1; req_src[k] = s; req_ctx[k] = x;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, base_iss, base_ack, tot;
        rst = 1'b1; k_intr_req = '0; k_intr_src = '0; k_intr_ctx = '0;
        host_intr_ready = 1'b0; host_rsp_valid = 1'b0; host_rsp_ok = 1'b0;
        req_v = '0; ready_always = 1'b1; rsp_delay_fixed = -1; ok_pct = 100;
        issues_total = 0; first_valid_tick = 0; last_issue_src = '0;
        prev_src = '0; prev_ctx = '0; prev_kid = '0; txn_kid = 0; txn_fails = 0; fail_edge = 0;
        for (int i = 0; i < NK; i++) begin
            ack_cnt[i] = 0; req_src[i] = '0; req_ctx[i] = '0; m_src[i] = '0; m_ctx[i] = '0;
        end
        reset_model();
        repeat (2) @(posedge clk);
        do_reset();

        // single request: latency and single ack
        rsp_delay_fixed = 2;
        t = cyc + 1;
        set_req(1, 64'h0000_0001_0000_1234, 9'd5);
        step();
        drain(200);
        check_eq("t1_latency", first_valid_tick, t + 2);
        check_eq("t1_src", last_issue_src, 64'h0000_0001_0000_1234);
        check_eq("t1_acks", ack_cnt[1], 1);

        // simultaneous requests, round-robin order
        do_reset();
        dut_kids.delete();
        set_req(0, 64'hA0, 9'd1); set_req(2, 64'hA2, 9'd2); set_req(3, 64'hA3, 9'd3);
        step();
        drain(300);
        check_eq("t2_count", dut_kids.size(), 3);
        if (dut_kids.size() == 3) begin
            check_eq("t2_first", dut_kids[0], 0);
            check_eq("t2_second", dut_kids[1], 2);
            check_eq("t2_third", dut_kids[2], 3);
        end
        dut_kids.delete();
        set_req(0, 64'hB0, 9'd7); set_req(3, 64'hB3, 9'd8);
        step();
        drain(300);
        check_eq("t2b_count", dut_kids.size(), 2);
        if (dut_kids.size() == 2) begin
            check_eq("t2b_first", dut_kids[0], 0);
            check_eq("t2b_second", dut_kids[1], 3);
        end

        // fail, fail, ok
        do_reset();
        rsp_plan = '{1'b0, 1'b0, 1'b1};
        base_iss = issues_total; base_ack = ack_cnt[1];
        set_req(1, 64'hC1, 9'd9);
        step();
        drain(300);
        check_eq("t3_issues", issues_total - base_iss, 3);
        check_eq("t3_acks", ack_cnt[1] - base_ack, 1);
        check_eq("t3_drop", err_drop, 0);

        // retries exhausted
        rsp_plan = '{1'b0, 1'b0, 1'b0, 1'b0};
        base_iss = issues_total; base_ack = ack_cnt[3];
        set_req(3, 64'hD3, 9'd11);
        step();
        drain(400);
        check_eq("t4_issues", issues_total - base_iss, 4);
        check_eq("t4_acks", ack_cnt[3] - base_ack, 1);
        check_eq("t4_drop", err_drop, 4'b1000);

        // overrun keeps first capture
        base_ack = ack_cnt[2];
        set_req(2, 64'h1111_2222_3333_4444, 9'd21);
        step();
        set_req(2, 64'h5555_6666_7777_8888, 9'd22);
        step();
        drain(300);
        check_eq("t5_overrun", err_overrun, 4'b0100);
        check_eq("t5_src", last_issue_src, 64'h1111_2222_3333_4444);
        check_eq("t5_acks", ack_cnt[2] - base_ack, 1);

        // randomized traffic
        do_reset();
        ready_always = 1'b0; rsp_delay_fixed = -1; ok_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, 15) == 0)
                    set_req(i, {$urandom, $urandom}, CTXW'($urandom));
            end
            step();
        end
        drain(3000);
        check_eq("rnd_overrun", err_overrun, exp_overrun);
        check_eq("rnd_drop", err_drop, exp_drop);
        check_eq("rnd_spurious", err_spurious, exp_spur);

        // reset while waiting for the host response
        do_reset();
        ready_always = 1'b1; rsp_delay_fixed = 6;
        set_req(0, 64'hE0, 9'd30);
        step();
        t = 0;
        while (!outstanding && t < 50) begin
            step();
            t++;
        end
        check_eq("t6_reached_wait", outstanding, 1);
        tot = 0;
        for (int i = 0; i < NK; i++) tot += ack_cnt[i];
        do_reset();
        repeat (8) step();
        force_spur = 1'b1;
        step();
        step();
        check_eq("t6_spurious", err_spurious, 1);
        check_eq("t6_drop", err_drop, 0);
        check_eq("t6_overrun", err_overrun, 0);
        for (int i = 0; i < NK; i++) tot -= ack_cnt[i];
        check_eq("t6_no_ack", tot, 0);
        check_eq("t6_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
